// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared constants for the MIPS pipeline register scoreboard
package pipeline_pkg;
   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam int NUM_REGS_DEF = 32;
   localparam int DATA_WIDTH_DEF = 32;
   localparam int PEND_WIDTH_DEF = 2;
   localparam int PEND_MAX = 2**PEND_WIDTH_DEF - 1;
endpackage

// File: rtl/register_scoreboard_pending_counter.sv
// pending_counter: saturating up/down count of outstanding writes to one register
module pending_counter #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         zero,
   output logic         full,
   output logic         underflow
);
   logic [W-1:0] count_q, count_d;
   assign count = count_q;
   assign zero = count_q == '0;
   assign full = &count_q;
   assign underflow = dec && !inc && zero;
   always_comb count_d = (inc && !dec && !full) ? count_q + W'(1) :
                         (dec && !inc && !zero) ? count_q - W'(1) : count_q;
   always_ff @(posedge clk) count_q <= reset ? '0 : count_d;
endmodule

// File: rtl/register_scoreboard.sv
// register_scoreboard: register file with write bypass and per-register pending-write
// scoreboard giving decode an operand-ready flag per source.
module register_scoreboard
   import pipeline_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int PEND_WIDTH = PEND_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4:0]            index1,
   input  logic [4:0]            index2,
   output logic [DATA_WIDTH-1:0] valueOutput1,
   output logic [DATA_WIDTH-1:0] valueOutput2,
   output logic                  flagOutput1,
   output logic                  flagOutput2,
   input  logic                  reserveEnable,
   input  logic [4:0]            reserveIndex,
   output logic                  reserveReady,
   input  logic                  writeEnable,
   input  logic [4:0]            writeIndex,
   input  logic [DATA_WIDTH-1:0] valueInput,
   output logic                  underflowError
);
   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [NUM_REGS-1:0][PEND_WIDTH-1:0] pend;
   logic [NUM_REGS-1:0] full_v, uf_v;
   logic underflow_q;
   logic rel1, rel2, wr_res;
   assign pend[0] = '0;
   assign full_v[0] = 1'b0;
   assign uf_v[0] = 1'b0;
   genvar i;
   generate
      for (i = 1; i < NUM_REGS; i++) begin : g_pend
         pending_counter #(.W(PEND_WIDTH)) u_cnt (
            .clk(clk),
            .reset(reset),
            .inc(reserveEnable && reserveReady && reserveIndex == 5'(i)),
            .dec(writeEnable && writeIndex == 5'(i)),
            .count(pend[i]),
            .zero(),
            .full(full_v[i]),
            .underflow(uf_v[i])
         );
      end
   endgenerate
   assign wr_res = writeEnable && writeIndex == reserveIndex;
   assign reserveReady = reserveIndex == REG_ZERO || !full_v[reserveIndex] || wr_res;
   assign rel1 = writeEnable && writeIndex == index1 && index1 != REG_ZERO;
   assign rel2 = writeEnable && writeIndex == index2 && index2 != REG_ZERO;
   assign valueOutput1 = rel1 ? valueInput : regs_q[index1];
   assign valueOutput2 = rel2 ? valueInput : regs_q[index2];
   // A release this cycle lowers the count by one; the comparison floors at zero.
   assign flagOutput1 = pend[index1] <= PEND_WIDTH'(rel1);
   assign flagOutput2 = pend[index2] <= PEND_WIDTH'(rel2);
   assign underflowError = underflow_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
         underflow_q <= 1'b0;
      end else begin
         if (writeEnable && writeIndex != REG_ZERO) regs_q[writeIndex] <= valueInput;
         underflow_q <= underflow_q | (|uf_v);
      end
   end
endmodule

// File: tb/tb_register_scoreboard.sv
// tb_register_scoreboard: directed vectors with hand-computed expectations
module tb_register_scoreboard;
   logic clk = 1'b0;
   logic reset;
   logic [4:0] index1, index2, reserveIndex, writeIndex;
   logic [31:0] valueOutput1, valueOutput2, valueInput;
   logic flagOutput1, flagOutput2, reserveEnable, reserveReady, writeEnable, underflowError;
   int checks = 0;
   int errors = 0;

   register_scoreboard dut (
      .clk(clk), .reset(reset),
      .index1(index1), .index2(index2),
      .valueOutput1(valueOutput1), .valueOutput2(valueOutput2),
      .flagOutput1(flagOutput1), .flagOutput2(flagOutput2),
      .reserveEnable(reserveEnable), .reserveIndex(reserveIndex), .reserveReady(reserveReady),
      .writeEnable(writeEnable), .writeIndex(writeIndex), .valueInput(valueInput),
      .underflowError(underflowError)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; index1 = 0; index2 = 0; reserveEnable = 0; reserveIndex = 0;
      writeEnable = 0; writeIndex = 0; valueInput = 0;
      tick(); tick();
      reset = 1'b0;
      index1 = 5; index2 = 0; #1;
      check("rst_v1", valueOutput1, 0);
      check("rst_v2", valueOutput2, 0);
      check("rst_f1", flagOutput1, 1);
      check("rst_f2", flagOutput2, 1);
      check("rst_err", underflowError, 0);
      check("rst_rr", reserveReady, 1);
      // reserve r8, then write it
      reserveEnable = 1; reserveIndex = 8;
      tick();
      reserveEnable = 0; index1 = 8; index2 = 8; #1;
      check("r8_f1_pend", flagOutput1, 0);
      check("r8_f2_pend", flagOutput2, 0);
      writeEnable = 1; writeIndex = 8; valueInput = 32'hDEADBEEF; #1;
      check("r8_byp_v1", valueOutput1, 32'hDEADBEEF);
      check("r8_byp_f1", flagOutput1, 1);
      check("r8_byp_v2", valueOutput2, 32'hDEADBEEF);
      tick();
      writeEnable = 0; valueInput = 0; #1;
      check("r8_reg_v1", valueOutput1, 32'hDEADBEEF);
      check("r8_reg_f1", flagOutput1, 1);
      check("r8_err", underflowError, 0);
      // fill r3 to saturation
      reserveEnable = 1; reserveIndex = 3; index1 = 3;
      tick(); tick(); tick();
      check("r3_full_rr", reserveReady, 0);
      check("r3_full_f1", flagOutput1, 0);
      tick();
      writeEnable = 1; writeIndex = 3; valueInput = 32'h11; #1;
      check("r3_wr_rr", reserveReady, 1);
      check("r3_wr_f1", flagOutput1, 0);
      tick();
      reserveEnable = 0; writeEnable = 0; #1;
      check("r3_stay3_rr", reserveReady, 0);
      writeEnable = 1; valueInput = 32'h22;
      tick(); tick();
      check("r3_last_f1", flagOutput1, 1);
      check("r3_last_v1", valueOutput1, 32'h22);
      tick();
      writeEnable = 0; #1;
      check("r3_free_f1", flagOutput1, 1);
      check("r3_free_rr", reserveReady, 1);
      check("r3_err", underflowError, 0);
      // same-cycle reserve does not affect the read
      reserveEnable = 1; reserveIndex = 4; index1 = 4; #1;
      check("r4_same_f1", flagOutput1, 1);
      tick();
      reserveEnable = 0; #1;
      check("r4_next_f1", flagOutput1, 0);
      writeEnable = 1; writeIndex = 4; valueInput = 32'h44; #1;
      check("r4_rel_f1", flagOutput1, 1);
      tick();
      writeEnable = 0; #1;
      check("r4_err", underflowError, 0);
      // write without reservation
      writeEnable = 1; writeIndex = 9; valueInput = 7; index1 = 9; index2 = 9; #1;
      check("r9_byp_v1", valueOutput1, 7);
      check("r9_byp_f1", flagOutput1, 1);
      check("r9_err_same", underflowError, 0);
      tick();
      writeEnable = 0; #1;
      check("r9_v2", valueOutput2, 7);
      check("r9_err", underflowError, 1);
      reset = 1; writeEnable = 1; writeIndex = 10; valueInput = 5;
      reserveEnable = 1; reserveIndex = 10;
      tick();
      reset = 0; writeEnable = 0; reserveEnable = 0; valueInput = 0; index2 = 10; #1;
      check("rst2_err", underflowError, 0);
      check("rst2_v1", valueOutput1, 0);
      check("rst2_r10_v", valueOutput2, 0);
      check("rst2_r10_f", flagOutput2, 1);
      // register zero
      writeEnable = 1; writeIndex = 0; valueInput = 32'hFFFFFFFF;
      reserveEnable = 1; reserveIndex = 0; index1 = 0; #1;
      check("r0_same_v1", valueOutput1, 0);
      check("r0_same_f1", flagOutput1, 1);
      check("r0_rr", reserveReady, 1);
      tick();
      writeEnable = 0; reserveEnable = 0; #1;
      check("r0_v1", valueOutput1, 0);
      check("r0_f1", flagOutput1, 1);
      check("r0_err", underflowError, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
